// File: rtl/shift_add_seq.sv
// Sequential shifted-operand adder: NUM_OPS operands arrive serially, operand k weighted by
// 2^(k*SHIFT); the truncated sum is emitted on a valid/ready port. Optional macro SHIFT_ADD_OVF_EN.
module shift_add_seq #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned NUM_OPS = 3,
  parameter int unsigned OUT_W   = IN_W + SHIFT * (NUM_OPS - 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o
`ifdef SHIFT_ADD_OVF_EN
  ,
  output logic             out_ovf_o
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_OPS);
  localparam int unsigned SumW = OUT_W + 1;
`ifdef SHIFT_ADD_OVF_EN
  localparam int unsigned AccW = OUT_W + 1;
`else
  localparam int unsigned AccW = OUT_W;
`endif
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OPS - 1);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [AccW-1:0]  acc_q;
  logic [OUT_W-1:0] out_data_q;
`ifdef SHIFT_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic [31:0]      shamt;
  logic [SumW-1:0]  operand;
  logic [SumW-1:0]  sum;
  logic [AccW-1:0]  acc_next;

  always_comb begin
    shamt   = 32'(idx_q) * SHIFT;
    operand = SumW'(in_data_i) << shamt;
    sum     = {1'b0, acc_q[OUT_W-1:0]} + operand;
`ifdef SHIFT_ADD_OVF_EN
    // Guard bit is sticky: any carry out of OUT_W marks the whole sum as overflowed.
    acc_next = {acc_q[OUT_W] | sum[OUT_W], sum[OUT_W-1:0]};
`else
    acc_next = sum[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StAcc;
      idx_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
`ifdef SHIFT_ADD_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else if (clr_i) begin
      // Abort beats any handshake; out_data keeps its last value.
      state_q <= StAcc;
      idx_q   <= '0;
      acc_q   <= '0;
`ifdef SHIFT_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StAcc: begin
          if (in_valid_i) begin
            acc_q <= acc_next;
            if (idx_q == LastIdx) begin
              out_data_q <= acc_next[OUT_W-1:0];
`ifdef SHIFT_ADD_OVF_EN
              ovf_q      <= acc_next[OUT_W];
`endif
              idx_q      <= '0;
              state_q    <= StHold;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StHold: begin
          if (out_ready_i) begin
            acc_q   <= '0;
            state_q <= StAcc;
`ifdef SHIFT_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == StAcc);
  assign out_valid_o = (state_q == StHold);
  assign out_data_o  = out_data_q;
`ifdef SHIFT_ADD_OVF_EN
  assign out_ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_shift_add_seq.sv
// Directed bench for shift_add_seq: default instance plus an IN_W=4/NUM_OPS=4 instance.
module tb_shift_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [15:0] out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0]  b_in_data;
  logic [15:0] b_out_data;
`ifdef SHIFT_ADD_OVF_EN
  logic        out_ovf, b_out_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_add_seq u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef SHIFT_ADD_OVF_EN
    ,
    .out_ovf_o   (out_ovf)
`endif
  );

  shift_add_seq #(
    .IN_W    (4),
    .SHIFT   (4),
    .NUM_OPS (4)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (1'b0),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (b_in_data),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .out_data_o  (b_out_data)
`ifdef SHIFT_ADD_OVF_EN
    ,
    .out_ovf_o   (b_out_ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid high across one edge; caller lowers it when the burst ends.
  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  task automatic send_b(input logic [3:0] d);
    b_in_valid = 1'b1;
    b_in_data  = d;
    tick();
    b_in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] b_ops [4];
    b_ops = '{4'hA, 4'hB, 4'hC, 4'hD};
    clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    #11 rst_n = 1'b1;
    tick();

    // 1: back-to-back operands, result one cycle after last handshake, one cycle wide
    send(8'h12);
    send(8'h34);
    check("t1_no_early_valid", 32'(out_valid), 32'h0);
    send(8'h56);
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'h5952);
    check("t1_in_ready_hold", 32'(in_ready), 32'h0);
`ifdef SHIFT_ADD_OVF_EN
    check("t1_ovf", 32'(out_ovf), 32'h0);
`endif
    tick();
    check("t1_valid_drop", 32'(out_valid), 32'h0);
    check("t1_in_ready_back", 32'(in_ready), 32'h1);

    // 2: maximum operands wrap
    send(8'hFF);
    send(8'hFF);
    send(8'hFF);
    in_valid = 1'b0;
    check("t2_data", 32'(out_data), 32'h0FEF);
`ifdef SHIFT_ADD_OVF_EN
    check("t2_ovf", 32'(out_ovf), 32'h1);
`endif
    tick();
`ifdef SHIFT_ADD_OVF_EN
    check("t2_ovf_cleared", 32'(out_ovf), 32'h0);
`endif

    // 3: backpressure holds the result
    out_ready = 1'b0;
    send(8'h12);
    send(8'h34);
    send(8'h56);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_valid", 32'(out_valid), 32'h1);
      check("t3_data", 32'(out_data), 32'h5952);
      check("t3_in_ready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t3_in_ready_after", 32'(in_ready), 32'h1);
    check("t3_valid_after", 32'(out_valid), 32'h0);

    // 4: clr drops a partial sum, even with an operand offered the same cycle
    send(8'h12);
    send(8'h34);
    clr = 1'b1;
    in_data = 8'h56;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    check("t4_no_result", 32'(out_valid), 32'h0);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    in_valid = 1'b0;
    check("t4_valid", 32'(out_valid), 32'h1);
    check("t4_data", 32'(out_data), 32'h0321);
    tick();

    // clr in HOLD: valid drops, data is kept
    out_ready = 1'b0;
    send(8'h0F);
    send(8'h00);
    send(8'h00);
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_clr_hold_valid", 32'(out_valid), 32'h0);
    check("t4_clr_hold_data", 32'(out_data), 32'h000F);
    check("t4_clr_hold_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;

    // 5: async reset mid-sequence
    send(8'h77);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_data", 32'(out_data), 32'h0);
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_ready", 32'(in_ready), 32'h1);
    #2 rst_n = 1'b1;
    tick();
    send(8'h01);
    send(8'h00);
    send(8'h00);
    in_valid = 1'b0;
    check("t5_valid", 32'(out_valid), 32'h1);
    check("t5_data", 32'(out_data), 32'h0001);
    tick();

    // 6: four 4-bit operands with random gaps
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      if (k == 3) check("t6_no_early_valid", 32'(b_out_valid), 32'h0);
      send_b(b_ops[k]);
    end
    check("t6_valid", 32'(b_out_valid), 32'h1);
    check("t6_data", 32'(b_out_data), 32'hDCBA);
    tick();
    check("t6_valid_drop", 32'(b_out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
